// File: rtl/acks_fifo.sv
// acks_fifo: 32-bit word FIFO behind the register bank's "acks" register.
//
// A bus write to that register pushes one word and a bus read pops one
// word. Each strobe is answered by a one-cycle acknowledge on the
// following cycle. Overflow and underflow never stall the bus. Instead
// they set sticky flags.
//
// Ports:
//   clk_i     - clock, all logic on the rising edge
//   rst_i     - synchronous active-high reset
//   wr_i      - push strobe (one cycle per bus write)
//   wr_dat_i  - push data, valid with wr_i
//   wack_o    - write acknowledge, one cycle after wr_i
//   rd_i      - pop strobe (one cycle per bus read)
//   rack_o    - read acknowledge, one cycle after rd_i
//   rd_dat_o  - popped word, registered, held until the next pop or clear
//   clr_i     - synchronous flush plus flag clear, overrides everything
//   level_o   - occupancy 0..DEPTH
//   empty_o   - level_o == 0
//   full_o    - level_o == DEPTH
//   ovf_o     - sticky: a push was dropped because the FIFO was full
//   udf_o     - sticky: a pop was attempted on an empty FIFO
//
// Handshake: each strobe is a single-cycle request with no back-pressure.
// Its ack is asserted for exactly the next cycle, whether or not the
// request had any effect. A strobe seen during reset is never acked.
module acks_fifo #(
    parameter int DEPTH = 16,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_i,
    input  logic [31:0]   wr_dat_i,
    output logic          wack_o,
    input  logic          rd_i,
    output logic          rack_o,
    output logic [31:0]   rd_dat_o,
    input  logic          clr_i,
    output logic [LW-1:0] level_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          ovf_o,
    output logic          udf_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [31:0]   mem_q [DEPTH];

    logic [LW-1:0] wptr_q, wptr_d;
    logic [LW-1:0] rptr_q, rptr_d;
    logic [31:0]   rd_dat_q, rd_dat_d;
    logic          wack_q, rack_q;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    // Pointers are one bit wider than the address, so full and empty
    // can be told apart. The subtraction wraps modulo 2*DEPTH.
    assign level = wptr_q - rptr_q;
    assign empty = (level == '0);
    assign full  = (level == DEPTH_L);

    // Emptiness and fullness are judged on the state before the edge.
    // A full FIFO can still take a push when a pop frees a slot in the
    // same cycle. The read of the oldest slot uses its old contents.
    assign pop_ok  = rd_i && !clr_i && !empty;
    assign push_ok = wr_i && !clr_i && (!full || rd_i);

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        rd_dat_d = rd_dat_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clr_i) begin
            wptr_d   = '0;
            rptr_d   = '0;
            rd_dat_d = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (push_ok) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (wr_i && full && !rd_i) begin
                ovf_d = 1'b1;
            end
            if (rd_i) begin
                if (pop_ok) begin
                    rd_dat_d = mem_q[rptr_q[AW-1:0]];
                    rptr_d   = rptr_q + 1'b1;
                end else begin
                    rd_dat_d = '0;
                    udf_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            rd_dat_q <= '0;
            wack_q   <= 1'b0;
            rack_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            rd_dat_q <= rd_dat_d;
            wack_q   <= wr_i;
            rack_q   <= rd_i;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage has no reset. Only locations below the write pointer are
    // ever read.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok) begin
            mem_q[wptr_q[AW-1:0]] <= wr_dat_i;
        end
    end

    assign wack_o   = wack_q;
    assign rack_o   = rack_q;
    assign rd_dat_o = rd_dat_q;
    assign level_o  = level;
    assign empty_o  = empty;
    assign full_o   = full;
    assign ovf_o    = ovf_q;
    assign udf_o    = udf_q;

endmodule

// File: doc/acks_fifo.md
# acks_fifo

Word FIFO placed directly downstream of the register bank's "acks" register, which uses write/read strobes with external acknowledges. A bus write to that register pushes one 32-bit word; a bus read pops one word. Each strobe is answered with a single-cycle acknowledge one cycle later, which completes the bank's bus cycle. Overflow and underflow are reported through sticky flags rather than by stalling the bus.

## Interface
- DEPTH, 16, number of 32-bit entries; power of two, minimum 2.
- LW, $clog2(DEPTH)+1, width of level_o; derived, not to be overridden.

- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high (fixed).
- wr_i  in  1  push strobe, one cycle per bus write (bank's acks_wr_o).
- wr_dat_i  in  32  push data, valid with wr_i (bank's acks_o).
- wack_o  out  1  write acknowledge (to bank's acks_wack_i).
- rd_i  in  1  pop strobe, one cycle per bus read (bank's acks_rd_o).
- rack_o  out  1  read acknowledge (to bank's acks_rack_i).
- rd_dat_o  out  32  popped word (to bank's acks_i); registered.
- clr_i  in  1  synchronous flush plus flag clear.
- level_o  out  LW  current occupancy, 0..DEPTH.
- empty_o  out  1  level_o == 0.
- full_o  out  1  level_o == DEPTH.
- ovf_o  out  1  sticky: a push was dropped because the FIFO was full.
- udf_o  out  1  sticky: a pop was attempted while the FIFO was empty.

## Operation
- Storage is DEPTH x 32 RAM/regs. Read and write pointers are LW bits wide and wrap naturally modulo 2*DEPTH. The address is the low $clog2(DEPTH) bits. level = wptr - rptr, LW-bit unsigned.
- Push (wr_i=1, clr_i=0):
  - Not full: store wr_dat_i at wptr, then wptr+1.
  - Full and no pop in the same cycle: word dropped, ovf_o set.
  - Full with a simultaneous pop: push accepted and level stays DEPTH.
- Pop (rd_i=1, clr_i=0):
  - Not empty: rd_dat_o <= mem[rptr], then rptr+1.
  - Empty: rd_dat_o <= 0, udf_o set, pointers unchanged.
  - Emptiness is judged on state before the edge. A push in the same cycle into an empty FIFO does not satisfy the pop: udf_o is set and the pushed word is stored.
- Acknowledge rule: every push gets wack_o=1 for exactly the next cycle, whether accepted or dropped. Every pop gets rack_o=1 for exactly the next cycle, whether it returned data or 0. Back-to-back strobes on consecutive cycles each get their own ack pulse.
- rd_dat_o holds its value until the next pop or clear. It is stable while rack_o=1.
- clr_i=1 has priority over everything in that cycle:
  - pointers reset to 0, rd_dat_o <= 0, ovf_o and udf_o cleared;
  - a wr_i or rd_i in the same cycle is still acked next cycle, but no word is stored, the pop returns 0, and no flag is set.
- ovf_o and udf_o stay set until clr_i or rst_i.

## Timing
- Reset values: wack_o=0, rack_o=0, rd_dat_o=0, level_o=0, empty_o=1, full_o=0, ovf_o=0, udf_o=0; pointers 0.
- Reset mid-operation: a strobe in the reset cycle gets no ack. An ack pending from the previous cycle is forced to 0 in the cycle after rst_i.
- Ack latency: exactly 1 cycle from strobe to ack. No combinational path from wr_i/rd_i to any output.
- level_o, empty_o, full_o are registered/derived from pointers and reflect a push/pop the cycle after the strobe, coincident with the ack.
- Flags assert coincident with the ack of the offending strobe.
- Throughput: one push and one pop per cycle, simultaneously.

## Test plan
- Reset, push 0x11111111, 0x22222222, 0x33333333 on consecutive cycles:
  - wack_o high for 3 consecutive cycles;
  - level_o steps 1, 2, 3; empty_o falls after the first push.
- With three words held, pop three times:
  - rack_o is 1 the cycle after each rd_i;
  - rd_dat_o reads 0x11111111, 0x22222222, 0x33333333 in order;
  - level_o returns to 0 and empty_o=1.
- DEPTH=16:
  - push 0..15, full_o=1;
  - push 0xDEADBEEF: wack_o pulses, ovf_o=1, level_o stays 16;
  - pop 16 times: returns 0..15, never 0xDEADBEEF.
- Empty FIFO, rd_i and wr_i (0xA5A5A5A5) in the same cycle:
  - next cycle rack_o=1, wack_o=1, rd_dat_o=0, udf_o=1, level_o=1;
  - the next pop returns 0xA5A5A5A5.
- Full FIFO, simultaneous push 0x55 and pop:
  - pop returns the oldest word; level_o stays 16; ovf_o stays 0.
- Pointer wrap: 40 alternating push/pop pairs return the data in order, with level_o never above 1.
- Clear and reset:
  - with level 5 and ovf_o=1, assert clr_i together with rd_i: next cycle rack_o=1, rd_dat_o=0, level_o=0, ovf_o=0, udf_o=0;
  - assert rst_i in the cycle right after a push: wack_o=0 in the cycle after reset.
